// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: two write ports (port 1 wins), write-first
// bypassed registered reads, optional hardwired zero register, busy scoreboard, debug tap.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int TAP_IDX  = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DATA_W-1:0]        tap_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TAP_A = ADDR_W'(TAP_IDX);

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] regs_nxt [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // Post-edge register contents; reads and the tap sample this, which gives write-first bypass.
    always_comb begin
        // NOTE: every comb output is assigned a default first so no path leaves it unassigned, which would infer a latch.
        regs_nxt = regs;
        if (we0) regs_nxt[wa0] = wd0;
        if (we1) regs_nxt[wa1] = wd1;
        if (ZERO_REG != 0) regs_nxt[0] = '0;
    end

    // A new reservation supersedes a same-cycle write-back to that register.
    always_comb begin
        busy_nxt = busy;
        if (we0) busy_nxt[wa0] = 1'b0;
        if (we1) busy_nxt[wa1] = 1'b0;
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the array is cleared by reset on purpose; it is the only initialisation, so no preload is relied on.
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < DEPTH; i++) regs[i] <= regs_nxt[i];
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_data[k*DATA_W +: DATA_W] <= regs_nxt[rd_addr[k*ADDR_W +: ADDR_W]];
                rd_busy[k]                  <= busy_nxt[rd_addr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tap_data <= '0;
        else        tap_data <= regs_nxt[TAP_A];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (16-bit, 8 entries, 2 read ports).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, rsv_en;
    logic [2:0]  wa0, wa1, rsv_addr;
    logic [15:0] wd0, wd1;
    logic [15:0] tap_data;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .tap_data(tap_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Advance one edge and settle before sampling outputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rd(3'd0, 3'd0);
        we0 = 1'b1; wa0 = 3'd7; wd0 = 16'hDEAD;
        cyc();
        cyc();
        check("reset_rd0", rd_data[15:0], 16'h0000);
        check("reset_tap", tap_data, 16'h0000);
        rst_n = 1'b1;
        idle();

        for (int a = 0; a < 8; a += 2) begin
            rd(3'(a), 3'(a + 1));
            cyc();
            check($sformatf("init_rd0_a%0d", a), rd_data[15:0], 16'h0000);
            check($sformatf("init_rd1_a%0d", a + 1), rd_data[31:16], 16'h0000);
            check($sformatf("init_busy_a%0d", a), {14'd0, rd_busy}, 16'h0000);
        end
        check("init_tap", tap_data, 16'h0000);

        we0 = 1'b1; wa0 = 3'd3; wd0 = 16'h1234;
        rd(3'd1, 3'd2);
        cyc();
        idle();
        rd(3'd3, 3'd3);
        cyc();
        check("wr3_rd0", rd_data[15:0], 16'h1234);
        check("wr3_rd1", rd_data[31:16], 16'h1234);

        we0 = 1'b1; wa0 = 3'd0; wd0 = 16'hFFFF;
        cyc();
        idle();
        rd(3'd0, 3'd3);
        cyc();
        check("zero_rd0", rd_data[15:0], 16'h0000);
        check("zero_keep3", rd_data[31:16], 16'h1234);

        we0 = 1'b1; wa0 = 3'd5; wd0 = 16'hAAAA;
        we1 = 1'b1; wa1 = 3'd5; wd1 = 16'h5555;
        rd(3'd5, 3'd3);
        cyc();
        idle();
        check("prio_bypass", rd_data[15:0], 16'h5555);
        rd(3'd4, 3'd5);
        cyc();
        check("prio_stored", rd_data[31:16], 16'h5555);

        we0 = 1'b1; wa0 = 3'd1; wd0 = 16'h1111;
        we1 = 1'b1; wa1 = 3'd2; wd1 = 16'h2222;
        rd(3'd1, 3'd2);
        cyc();
        idle();
        check("dual_bypass0", rd_data[15:0], 16'h1111);
        check("dual_bypass1", rd_data[31:16], 16'h2222);

        rsv_en = 1'b1; rsv_addr = 3'd6;
        rd(3'd5, 3'd5);
        cyc();
        idle();
        check("rsv_other", {14'd0, rd_busy}, 16'h0000);
        rd(3'd6, 3'd5);
        cyc();
        check("rsv6_busy", {14'd0, rd_busy}, 16'h0001);

        we1 = 1'b1; wa1 = 3'd6; wd1 = 16'h0007;
        rd(3'd5, 3'd6);
        cyc();
        idle();
        check("wr6_clear_bypass", {14'd0, rd_busy}, 16'h0000);
        check("wr6_data_bypass", rd_data[31:16], 16'h0007);
        rd(3'd6, 3'd6);
        cyc();
        check("wr6_busy", {14'd0, rd_busy}, 16'h0000);
        check("wr6_data", rd_data[15:0], 16'h0007);

        rsv_en = 1'b1; rsv_addr = 3'd6;
        we0 = 1'b1; wa0 = 3'd6; wd0 = 16'h0009;
        rd(3'd6, 3'd0);
        cyc();
        idle();
        check("rsv_wins_bypass", {14'd0, rd_busy}, 16'h0001);
        check("rsv_wins_data", rd_data[15:0], 16'h0009);
        cyc();
        check("rsv_wins_hold", {14'd0, rd_busy}, 16'h0001);

        rsv_en = 1'b1; rsv_addr = 3'd0;
        rd(3'd6, 3'd0);
        cyc();
        idle();
        check("rsv_zero_busy", {14'd0, rd_busy}, 16'h0001);

        check("tap_before", tap_data, 16'h0000);
        we0 = 1'b1; wa0 = 3'd7; wd0 = 16'h0002;
        cyc();
        idle();
        check("tap_after", tap_data, 16'h0002);

        rsv_en = 1'b1; rsv_addr = 3'd2;
        cyc();
        idle();
        we0 = 1'b1; wa0 = 3'd4; wd0 = 16'h00FF;
        rd(3'd4, 3'd2);
        cyc();
        idle();
        check("pre_rst_data4", rd_data[15:0], 16'h00FF);
        check("pre_rst_busy2", {14'd0, rd_busy}, 16'h0002);
        rst_n = 1'b0;
        we1 = 1'b1; wa1 = 3'd1; wd1 = 16'hBEEF;
        rsv_en = 1'b1; rsv_addr = 3'd3;
        cyc();
        check("mid_rst_data", rd_data[15:0], 16'h0000);
        check("mid_rst_tap", tap_data, 16'h0000);
        rst_n = 1'b1;
        idle();
        rd(3'd4, 3'd2);
        cyc();
        check("post_rst_data4", rd_data[15:0], 16'h0000);
        check("post_rst_busy", {14'd0, rd_busy}, 16'h0000);
        rd(3'd1, 3'd3);
        cyc();
        check("post_rst_data1", rd_data[15:0], 16'h0000);
        check("post_rst_busy3", {14'd0, rd_busy}, 16'h0000);
        check("post_rst_tap", tap_data, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined datapath; the successor to the fixed 8x16, 2-read/1-write register file.
- Widths, depth and read-port count are set by parameters.
- Adds a second write port, write-first bypass on reads, an optional hardwired-zero register, a per-register busy scoreboard for hazard detection, and a registered debug tap.
- Sits between decode (read ports, reservations) and writeback (write ports).

Parameters:
- DATA_W, 16, width of each register in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes and reservations.
- TAP_IDX, 7, index of the register mirrored on tap_data.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data; port k is bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  registered busy flag for each read address.
- we0  in  1  write enable, port 0 (writeback).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (load return / late writeback).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- rsv_en  in  1  mark register rsv_addr as having a pending producer.
- rsv_addr  in  ADDR_W  register to reserve.
- tap_data  out  DATA_W  registered copy of register TAP_IDX.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All registers cleared to 0; all busy bits cleared.
  - rd_data, rd_busy and tap_data driven to 0 on the following cycle.
  - All write, reserve and read activity in a reset cycle is discarded.
  - Asserting reset mid-operation discards any pending reservations.
- Writes:
  - Commit at the rising edge where weN=1.
  - Port 1 has priority: if we0=we1=1 and wa0==wa1, wd1 is stored and wd0 is dropped.
  - With ZERO_REG=1, any write to address 0 is ignored.
- Reads:
  - Latency is 1 cycle: rd_data[k] at edge t+1 reflects rd_addr[k] sampled at edge t.
  - Write-first bypass: if a write to the same address commits at that edge, rd_data returns the written value (port 1 beats port 0, per write priority).
  - With ZERO_REG=1, reading address 0 always returns 0 and rd_busy=0.
  - Multiple read ports reading the same address return identical data.
- Scoreboard: one busy bit per register.
  - rsv_en=1 sets busy[rsv_addr].
  - A committed write to address a clears busy[a].
  - If a write and a reservation target the same register in the same cycle, the reservation wins and busy stays 1 (the new producer supersedes the old one).
  - Writes to a non-busy register are legal and leave busy at 0.
  - rd_busy[k] is registered and reflects the busy state after that edge's updates; this is consistent with the bypass rule.
- tap_data: registered value of register TAP_IDX after that edge's writes, i.e. tap_data shows the new value one cycle after the write.
- Width/range rules:
  - Addresses are always in range because depth = 2**ADDR_W.
  - Data is stored unmodified; no sign handling.
- Implementation constraints:
  - No combinational path from inputs to outputs.
  - Non-blocking assignments only.
  - No initial-block preload; reset is the sole initialisation mechanism.

Test Plan:
- Reset then read: hold rst_n=0 for 2 cycles, release, read addresses 0..7 on ports 0/1 -> every rd_data=0x0000, rd_busy=0, tap_data=0x0000.
- Write then read: we0=1, wa0=3, wd0=0x1234; next cycle read addr 3 on both ports -> both return 0x1234 one cycle later. Write 0xFFFF to addr 0 -> reads back 0x0000.
- Bypass and priority: same cycle we0=1/wa0=5/wd0=0xAAAA, we1=1/wa1=5/wd1=0x5555, rd_addr0=5 -> rd_data0=0x5555 next cycle; later read of addr 5 also returns 0x5555.
- Scoreboard: rsv_en for addr 6, then read 6 -> rd_busy=1. Write 6 with 0x0007 -> next read shows rd_busy=0, data 0x0007. Reserve 6 and write 6 in the same cycle -> rd_busy stays 1.
- Tap: write TAP_IDX=7 with 0x0002 -> tap_data=0x0002 one cycle after the write edge.
- Reset mid-operation: reserve addr 2, write addr 4=0x00FF, then pulse rst_n=0 -> afterwards addr 4 reads 0x0000 and addr 2 reads rd_busy=0. Re-run with DATA_W=32, ADDR_W=4, NUM_RD=3 -> all scenarios pass.
